// File: rtl/condlogic_pipe.sv
// Execute-stage condition unit: NZCV flag register, condition decode, gated controls carried
// through M/W registers, and saturating executed/skipped counters. Option: CONDLOGIC_NV_UNDEF_EN.
module condlogic_pipe #(
    parameter int unsigned FLAG_GROUPS = 2,  // legal: 1, 2, 4
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   StallE,
    input  logic                   FlushE,
    input  logic [3:0]             CondE,
    input  logic [3:0]             ALUFlags,
    input  logic [FLAG_GROUPS-1:0] FlagWE,
    input  logic                   PCSE,
    input  logic                   RegWE,
    input  logic                   MemWE,
    input  logic                   BranchE,
    output logic                   CondExE,
    output logic                   BranchTakenE,
    output logic [3:0]             Flags,
    output logic                   PCSrcM,
    output logic                   RegWriteM,
    output logic                   MemWriteM,
    output logic                   PCSrcW,
    output logic                   RegWriteW,
`ifdef CONDLOGIC_NV_UNDEF_EN
    output logic                   UndefM,
`endif
    output logic [CNT_W-1:0]       ExecCount,
    output logic [CNT_W-1:0]       SkipCount
);

    logic [3:0]       flags_q, flags_d;
    logic [3:0]       flag_wr;
    logic             n, z, c, v;
    logic             cond_ex;
    logic             nv_cond;
    logic             valid;
    logic             count_en;
    logic             pcs_g, regw_g, memw_g;
    logic             pcs_m_q, regw_m_q, memw_m_q;
    logic             pcs_w_q, regw_w_q;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] skip_q, skip_d;

    assign {n, z, c, v} = flags_q;
    assign nv_cond      = (CondE == 4'b1111);
    assign valid        = ~FlushE & ~StallE;

    always_comb begin
        cond_ex = 1'b0;
        case (CondE)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = BranchE & cond_ex & ~FlushE;

    assign pcs_g  = PCSE & cond_ex & ~FlushE;
    assign regw_g = RegWE & cond_ex & ~FlushE;
    assign memw_g = MemWE & cond_ex & ~FlushE;

    // Each flag bit follows the write enable of the group that owns it.
    for (genvar b = 0; b < 4; b++) begin : g_flag_wr
        assign flag_wr[b] = FlagWE[b * FLAG_GROUPS / 4];
    end

    always_comb begin
        flags_d = flags_q;
        if (valid && cond_ex) begin
            for (int b = 0; b < 4; b++) begin
                if (flag_wr[b]) flags_d[b] = ALUFlags[b];
            end
        end
    end

`ifdef CONDLOGIC_NV_UNDEF_EN
    logic undef_m_q;
    assign count_en = valid & ~nv_cond;
    assign UndefM   = undef_m_q;
`else
    assign count_en = valid;
    logic unused_nv;
    assign unused_nv = nv_cond;
`endif

    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (count_en) begin
            if (cond_ex) begin
                if (exec_q != {CNT_W{1'b1}}) exec_d = exec_q + 1'b1;
            end else begin
                if (skip_q != {CNT_W{1'b1}}) skip_d = skip_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            pcs_m_q  <= 1'b0;
            regw_m_q <= 1'b0;
            memw_m_q <= 1'b0;
            pcs_w_q  <= 1'b0;
            regw_w_q <= 1'b0;
            exec_q   <= '0;
            skip_q   <= '0;
`ifdef CONDLOGIC_NV_UNDEF_EN
            undef_m_q <= 1'b0;
`endif
        end else if (!StallE) begin
            flags_q  <= flags_d;
            pcs_m_q  <= pcs_g;
            regw_m_q <= regw_g;
            memw_m_q <= memw_g;
            pcs_w_q  <= pcs_m_q;
            regw_w_q <= regw_m_q;
            exec_q   <= exec_d;
            skip_q   <= skip_d;
`ifdef CONDLOGIC_NV_UNDEF_EN
            undef_m_q <= valid & nv_cond;
`endif
        end
    end

    assign Flags     = flags_q;
    assign PCSrcM    = pcs_m_q;
    assign RegWriteM = regw_m_q;
    assign MemWriteM = memw_m_q;
    assign PCSrcW    = pcs_w_q;
    assign RegWriteW = regw_w_q;
    assign ExecCount = exec_q;
    assign SkipCount = skip_q;

endmodule

// File: tb/tb_condlogic_pipe.sv
// Randomized + directed bench for condlogic_pipe against a behavioural model; a second
// instance with 4-bit counters exercises saturation.
module tb_condlogic_pipe;

    localparam int unsigned FG = 2;

    logic          clk = 1'b0;
    logic          reset, StallE, FlushE;
    logic [3:0]    CondE, ALUFlags;
    logic [FG-1:0] FlagWE;
    logic          PCSE, RegWE, MemWE, BranchE;
    logic          CondExE, BranchTakenE;
    logic [3:0]    Flags;
    logic          PCSrcM, RegWriteM, MemWriteM, PCSrcW, RegWriteW;
    logic [15:0]   ExecCount, SkipCount;
    logic          c4_condex, c4_btaken;
    logic [3:0]    c4_flags;
    logic          c4_pcsm, c4_regm, c4_memm, c4_pcsw, c4_regw;
    logic [3:0]    c4_exec, c4_skip;
`ifdef CONDLOGIC_NV_UNDEF_EN
    logic          UndefM, c4_undef;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [3:0] m_flags;
    bit         m_pcs_m, m_reg_m, m_mem_m, m_pcs_w, m_reg_w, m_undef;
    int         m_exec, m_skip;

    always #5 clk = ~clk;

    condlogic_pipe #(.FLAG_GROUPS(FG), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .CondE(CondE),
        .ALUFlags(ALUFlags), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
        .BranchE(BranchE), .CondExE(CondExE), .BranchTakenE(BranchTakenE), .Flags(Flags),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .PCSrcW(PCSrcW),
        .RegWriteW(RegWriteW),
`ifdef CONDLOGIC_NV_UNDEF_EN
        .UndefM(UndefM),
`endif
        .ExecCount(ExecCount), .SkipCount(SkipCount)
    );

    condlogic_pipe #(.FLAG_GROUPS(FG), .CNT_W(4)) dut_c4 (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .CondE(CondE),
        .ALUFlags(ALUFlags), .FlagWE(FlagWE), .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE),
        .BranchE(BranchE), .CondExE(c4_condex), .BranchTakenE(c4_btaken), .Flags(c4_flags),
        .PCSrcM(c4_pcsm), .RegWriteM(c4_regm), .MemWriteM(c4_memm), .PCSrcW(c4_pcsw),
        .RegWriteW(c4_regw),
`ifdef CONDLOGIC_NV_UNDEF_EN
        .UndefM(c4_undef),
`endif
        .ExecCount(c4_exec), .SkipCount(c4_skip)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Conditions come in pairs: even code tests a predicate, odd code its complement.
    function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
        bit nf = f[3], zf = f[2], cf = f[1], vf = f[0];
        bit base;
        if (code == 4'd14) return 1'b1;
        if (code == 4'd15) return 1'b0;
        case (code >> 1)
            0: base = zf;
            1: base = cf;
            2: base = nf;
            3: base = vf;
            4: base = cf && !zf;
            5: base = (nf == vf);
            default: base = !zf && (nf == vf);
        endcase
        return code[0] ? !base : base;
    endfunction

    function automatic int sat(input int x, input int w);
        int mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic step(input bit rst, input bit st, input bit fl, input logic [3:0] c,
                        input logic [3:0] af, input logic [FG-1:0] fw, input bit pcs,
                        input bit rw, input bit mw, input bit br);
        bit pass, nv_undef;
        int lo, hi;
        @(negedge clk);
        reset = rst; StallE = st; FlushE = fl; CondE = c; ALUFlags = af; FlagWE = fw;
        PCSE = pcs; RegWE = rw; MemWE = mw; BranchE = br;
        #1;
        pass = cond_ok(c, m_flags);
        if (!rst) begin
            check_eq("condex", CondExE, pass);
            check_eq("btaken", BranchTakenE, br && pass && !fl);
        end
        @(posedge clk);
`ifdef CONDLOGIC_NV_UNDEF_EN
        nv_undef = (c == 4'hF);
`else
        nv_undef = 1'b0;
`endif
        if (rst) begin
            m_flags = 4'b0; m_pcs_m = 0; m_reg_m = 0; m_mem_m = 0; m_pcs_w = 0; m_reg_w = 0;
            m_undef = 0; m_exec = 0; m_skip = 0;
        end else if (!st) begin
            m_pcs_w = m_pcs_m;
            m_reg_w = m_reg_m;
            m_pcs_m = pcs && pass && !fl;
            m_reg_m = rw && pass && !fl;
            m_mem_m = mw && pass && !fl;
            m_undef = !fl && nv_undef;
            if (!fl) begin
                if (pass) begin
                    for (int g = 0; g < FG; g++) begin
                        lo = g * 4 / FG;
                        hi = (g + 1) * 4 / FG - 1;
                        if (fw[g]) for (int b = lo; b <= hi; b++) m_flags[b] = af[b];
                    end
                end
                if (!nv_undef) begin
                    if (pass) m_exec++;
                    else m_skip++;
                end
            end
        end
        #1;
        check_eq("flags", Flags, m_flags);
        check_eq("pcsrc_m", PCSrcM, m_pcs_m);
        check_eq("regwrite_m", RegWriteM, m_reg_m);
        check_eq("memwrite_m", MemWriteM, m_mem_m);
        check_eq("pcsrc_w", PCSrcW, m_pcs_w);
        check_eq("regwrite_w", RegWriteW, m_reg_w);
        check_eq("exec_cnt", ExecCount, sat(m_exec, 16));
        check_eq("skip_cnt", SkipCount, sat(m_skip, 16));
        check_eq("exec_cnt4", c4_exec, sat(m_exec, 4));
        check_eq("skip_cnt4", c4_skip, sat(m_skip, 4));
`ifdef CONDLOGIC_NV_UNDEF_EN
        check_eq("undef_m", UndefM, m_undef);
`endif
    endtask

    // Plain instruction, no stall/flush/reset.
    task automatic instr(input logic [3:0] c, input logic [3:0] af, input logic [FG-1:0] fw,
                         input bit rw, input bit mw);
        step(1'b0, 1'b0, 1'b0, c, af, fw, 1'b0, rw, mw, 1'b0);
    endtask

    initial begin
        step(1, 0, 0, 4'hE, 4'h0, '0, 0, 0, 0, 0);
        check_eq("rst_exec", ExecCount, 0);
        check_eq("rst_flags", Flags, 0);

        // AL register write flows to M then W
        instr(4'hE, 4'h0, 2'b00, 1, 0);
        check_eq("al_regm", RegWriteM, 1);
        check_eq("al_exec1", ExecCount, 1);
        check_eq("al_skip0", SkipCount, 0);
        step(0, 0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        check_eq("al_regw", RegWriteW, 1);
        check_eq("flush_bubble", RegWriteM, 0);

        // Flags set, then EQ passes and NE fails
        instr(4'hE, 4'b0100, 2'b11, 0, 0);
        check_eq("flags_z", Flags, 4'b0100);
        instr(4'h0, 4'h0, 2'b00, 0, 1);
        check_eq("eq_memm", MemWriteM, 1);
        instr(4'hE, 4'b0100, 2'b11, 0, 0);
        instr(4'h1, 4'h0, 2'b00, 0, 1);
        check_eq("ne_memm", MemWriteM, 0);
        check_eq("ne_skip", SkipCount, 1);

        // Group write: only the low group (C,V) is cleared
        instr(4'hE, 4'b1111, 2'b11, 0, 0);
        instr(4'hE, 4'b0000, 2'b01, 0, 0);
        check_eq("group_lo", Flags, 4'b1100);

        // Failing conditional flag-setter leaves flags alone
        instr(4'hE, 4'b0000, 2'b11, 0, 0);
        instr(4'h0, 4'b1111, 2'b11, 1, 0);
        check_eq("fail_flags", Flags, 4'b0000);
        check_eq("fail_regm", RegWriteM, 0);

        // Stall holds everything
        instr(4'hE, 4'h0, 2'b00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, i[0], 4'hE, 4'hF, 2'b11, 1, 0, 1, 1);
            check_eq("stall_regm", RegWriteM, 1);
        end
        step(0, 0, 1, 4'hE, 4'h0, 2'b00, 1, 1, 1, 0);
        check_eq("flush_regm", RegWriteM, 0);

        // Saturation of the 4-bit counter
        step(1, 0, 0, 4'hE, 4'h0, '0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) instr(4'hE, 4'h0, 2'b00, 1, 0);
        check_eq("sat15", c4_exec, 15);
        check_eq("nosat16", ExecCount, 20);

        // Reset wins over stall
        step(1, 1, 0, 4'hE, 4'h0, '0, 0, 0, 0, 0);
        check_eq("rst_stall_exec", ExecCount, 0);
        check_eq("rst_stall_regm", RegWriteM, 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), FG'($urandom_range(0, (1 << FG) - 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/condlogic_pipe.md
Name: condlogic_pipe

Overview:
- Pipelined, parametrised condition unit for the pipelined ARM core; sits in the Execute stage.
- Holds the architectural NZCV flag register with a configurable number of independently written flag groups.
- Evaluates the Execute-stage condition field and gates the register-write, memory-write, PC-write and branch controls.
- Carries the gated controls through registered Memory and Writeback stages, with stall, flush and executed/annulled instruction counters.

Parameters:
- FLAG_GROUPS, 2, number of flag write groups; legal values 1, 2, 4. Flag bits [3:0] = {N,Z,C,V}, split evenly. Group g covers bits [(g+1)*4/FLAG_GROUPS-1 : g*4/FLAG_GROUPS].
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- StallE  in  1  freezes all state in this block for the cycle
- FlushE  in  1  annuls the current Execute instruction
- CondE  in  4  ARM condition field of the Execute instruction
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
- FlagWE  in  FLAG_GROUPS  per-group flag write request
- PCSE, RegWE, MemWE, BranchE  in  1 each  ungated Execute controls
- CondExE  out  1  condition passed (combinational)
- BranchTakenE  out  1  BranchE & CondExE & ~FlushE (combinational)
- Flags  out  4  current flag register
- PCSrcM, RegWriteM, MemWriteM  out  1 each  gated controls, Memory stage
- PCSrcW, RegWriteW  out  1 each  gated controls, Writeback stage
- ExecCount  out  CNT_W  instructions whose condition passed
- SkipCount  out  CNT_W  instructions annulled by condition

Behaviour:
- Reset: synchronous, active-high. Flags, all M/W outputs and both counters are 0 on the first clk edge with reset=1. Reset overrides StallE and FlushE.
- Condition decode (standard ARM), all combinational on Flags:
  - EQ/NE: Z / ~Z
  - CS/CC: C / ~C
  - MI/PL: N / ~N
  - VS/VC: V / ~V
  - HI: C&~Z; LS: ~C|Z
  - GE: N==V; LT: N!=V
  - GT: ~Z&(N==V); LE: Z|(N!=V)
  - AL (1110): 1
  - 1111: see Optional Feature.
- Valid Execute instruction: v = ~FlushE & ~StallE.
- Gated controls: X_g = X & CondExE & ~FlushE for PCS, RegW, MemW.
- Flag update:
  - On the clk edge with v=1, group g loads ALUFlags bits iff FlagWE[g] & CondExE.
  - Groups not written hold their value.
- Flag timing:
  - The new flags are visible to the next instruction's condition one cycle later. No bypass; the E-stage condition always uses registered Flags.
  - An instruction that both sets flags and is conditional evaluates against the old flags.
- Pipeline registers:
  - When StallE=0: M <= gated E controls; W <= M.
  - When StallE=1: M, W, Flags and counters hold.
  - FlushE with StallE=0 inserts a bubble (zeros) into M.
- Latency: E gated control appears on the M output 1 cycle later and on the W output 2 cycles later.
- Counters, updated only when v=1:
  - CondExE=1 increments ExecCount; otherwise SkipCount increments.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - Flushed and stalled cycles count in neither.
- BranchTakenE is asserted even if StallE=1. The hazard unit qualifies it.

Optional Feature:
- Macro: CONDLOGIC_NV_UNDEF_EN.
- Enabled:
  - Cond 1111 gives CondExE=0.
  - Adds output UndefM (1 bit, reset 0), registered like the M controls. It is set for a valid (v=1) instruction with CondE=1111.
  - The instruction is counted in neither counter.
- Disabled:
  - Cond 1111 gives CondExE=0 and counts in SkipCount.
  - UndefM port does not exist.

Test Plan:
- Reset, then CondE=1110, RegWE=1, MemWE=0 for 1 cycle -> CondExE=1; RegWriteM=1 at +1 cycle; RegWriteW=1 at +2; ExecCount=1; SkipCount=0.
- FlagWE=2'b11, ALUFlags=4'b0100, CondE=1110 (AL); next cycle CondE=0000 (EQ), MemWE=1 -> Flags=4'b0100; MemWriteM=1. Same sequence with CondE=0001 (NE) -> MemWriteM=0; SkipCount increments.
- FLAG_GROUPS=2, Flags=4'b1111; FlagWE=2'b01, ALUFlags=4'b0000 -> Flags=4'b1100 (only C,V cleared).
- Conditional flag-setting instruction whose condition fails (CondE=0000, Z=0, FlagWE=2'b11) -> Flags unchanged; RegWriteM=0.
- StallE=1 for 3 cycles, with RegWriteM=1 already registered -> RegWriteM, RegWriteW, Flags and counters all hold. FlushE=1 with StallE=0 -> M bubble of zeros; counters unchanged.
- CNT_W=4: 20 back-to-back AL instructions -> ExecCount stops at 15. Reset asserted during a stall -> all outputs 0 on the next edge.
